mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequential controller wrapped around the combinational 8x8 Dadda multiply-accumulate datapath (sum = a*b + x, 17-bit result as 16-bit sum plus carry). It accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and presents each pair to the datapath with its own accumulator register as the addend. It registers each result back into the accumulator, and after a programmed vector length delivers a 16-bit dot-product with a sticky overflow flag over a second valid/ready handshake. It sits between the operand source and the result consumer, and owns the only state in the MAC path.

## Interface
- LEN_W, 8, width of the vector-length field; maximum length is 2^LEN_W-1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a new accumulation; sampled only in IDLE
- len  in  LEN_W  number of operand pairs to accumulate; sampled with start
- init  in  16  initial accumulator value; sampled with start
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller accepts a pair this cycle
- in_a, in_b  in  8 each  unsigned operands
- mac_a, mac_b  out  8 each  operands driven to the datapath
- mac_x  out  16  addend driven to the datapath (the accumulator)
- mac_sum  in  16  datapath sum
- mac_cout  in  1  datapath carry (bit 16)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  16  accumulated result
- out_ovf  out  1  sticky: some step produced a carry
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, ACCUM, DONE. Reset: state IDLE; acc, count, ovf = 0; in_ready, out_valid, busy = 0.
- IDLE: start=1 loads acc<=init, ovf<=0, count<=0, len_r<=len. If len==0, go to DONE; otherwise go to ACCUM.
- ACCUM: in_ready=1. A beat is accepted on in_valid&in_ready.
  - On a beat: acc<=next, ovf<=ovf|mac_cout, count<=count+1.
  - If the beat is the one with count==len_r-1, go to DONE.
  - With no beat, hold all state.
- mac_a=in_a, mac_b=in_b, mac_x=acc. These are continuous combinational assignments, so the datapath result is consumed in the same cycle.
- next = mac_sum. This is wrap-around modulo 2^16 unless saturation is compiled in (see Configuration).
- DONE: out_valid=1, out_acc=acc, out_ovf=ovf. On out_ready, go to IDLE. Values stay stable while out_ready=0.
- start is ignored outside IDLE. in_valid is ignored outside ACCUM, and in_ready is 0 there.
- out_acc and out_ovf hold their last values in IDLE. Their reset value is 0.
- Reset mid-operation: an immediate return to reset values. Any partial result is discarded and no output is produced.

## Timing
- Start-to-ACCUM: 1 cycle.
- The result is out_valid in the cycle after the last accepted beat. Minimum start-to-out_valid latency is len+1 cycles. For len=0 it is 1 cycle.
- Full throughput is one pair per cycle with no bubbles between beats.
- Back-to-back vectors: out_ready in DONE returns to IDLE. The next start is sampled one cycle later, so the minimum gap is 1 idle cycle.
- The combinational loop acc -> mac_x -> datapath -> mac_sum -> acc is broken only by the acc register. The clock period must exceed the full datapath delay (partial products, reduction layers, prefix adder).

## Configuration
- MAC_SATURATE_EN defined: on a beat with mac_cout=1, acc<=16'hFFFF. Because operands are unsigned, a saturated accumulator stays at FFFF for the rest of the vector.
- MAC_SATURATE_EN undefined: acc<=mac_sum (wrap).
- ovf is sticky and reported identically in both builds.

## Test plan
- init=0, len=3, pairs (3,4),(5,6),(7,8), with in_valid held and out_ready=1 -> out_acc=16'h0062, out_ovf=0, out_valid exactly 4 cycles after start.
- init=16'hFFF0, len=1, pair (255,255) -> wrap build: out_acc=16'hFDF1, out_ovf=1; MAC_SATURATE_EN build: out_acc=16'hFFFF, out_ovf=1.
- init=16'h1234, len=0 -> out_valid one cycle after start with out_acc=16'h1234, out_ovf=0; in_ready never asserted.
- len=2, pairs (10,10),(2,3) with in_valid low for 3 cycles between them, and out_ready low for 5 cycles -> out_acc=16'h006A held stable with out_valid high until out_ready; start pulses during ACCUM/DONE are ignored.
- len=4, rst asserted asynchronously after 2 beats -> all outputs 0 and state IDLE immediately. A following start with init=0, len=1, pair (1,1) gives out_acc=16'h0001.
- Exhaustive-sample check: 1000 random vectors, len 1-16 -> out_acc equals (init + sum of a*b) mod 2^16 (or saturated per build), and out_ovf equals (true sum > 16'hFFFF).

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Accumulates len operand pairs through an external MAC datapath and returns a 16-bit dot product plus a sticky overflow flag.
// Result is valid the cycle after the last beat, held until out_ready; optional MAC_SATURATE_EN clamps acc at 16'hFFFF on carry.
module mac_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      init,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic [15:0]      mac_x,
  input  logic [15:0]      mac_sum,
  input  logic             mac_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      next_acc;

`ifdef MAC_SATURATE_EN
  // Unsigned operands only ever grow the sum, so a clamped acc stays clamped.
  assign next_acc = mac_cout ? 16'hFFFF : mac_sum;
`else
  assign next_acc = mac_sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = init;
          ovf_d   = 1'b0;
          count_d = '0;
          len_d   = len;
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d   = next_acc;
          ovf_d   = ovf_q | mac_cout;
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // The acc register is the only break in the acc -> datapath -> acc loop.
  assign mac_a     = in_a;
  assign mac_b     = in_b;
  assign mac_x     = acc_q;
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed and random vectors for mac_seq_ctrl, with a behavioural MAC datapath closing the loop.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [15:0] init;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic [7:0]  mac_a, mac_b;
  logic [15:0] mac_x;
  logic [15:0] mac_sum;
  logic        mac_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_acc;
  logic        out_ovf;
  logic        busy;

  logic [16:0] dp;
  assign dp = 17'(mac_a) * 17'(mac_b) + 17'(mac_x);
  assign {mac_cout, mac_sum} = dp;

  mac_seq_ctrl #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .init(init),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_x(mac_x), .mac_sum(mac_sum), .mac_cout(mac_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int t0   = 0;
  int lat  = 0;
  logic mon = 1'b0;
  logic saw_rdy = 1'b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (mon && in_ready) saw_rdy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after start is sampled.
  task automatic do_start(input logic [15:0] i, input logic [7:0] l);
    start = 1'b1; init = i; len = l; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, output int waits);
    in_valid = 1'b1; in_a = a; in_b = b; waits = 0;
    while (!in_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 40) chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [15:0] ea, input logic eo, input int hold);
    int n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0;
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      if (k == 2) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_acc"}, {16'd0, out_acc}, {16'd0, ea});
    end
    chk({tag, "_acc"}, {16'd0, out_acc}, {16'd0, ea});
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_keep"}, {16'd0, out_acc}, {16'd0, ea});
  endtask

  initial begin
    int w;
    logic [31:0] tsum;
    logic [15:0] ri;
    logic [7:0]  rl, ra, rb;
    logic [15:0] ea;

    rst = 1'b1; start = 1'b0; len = '0; init = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_acc", {16'd0, out_acc}, 32'd0);
    chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic three-pair vector at full rate.
    out_ready = 1'b0;
    do_start(16'h0000, 8'd3);
    beat(8'd3, 8'd4, w); chk("t1_b0_wait", w, 0);
    beat(8'd5, 8'd6, w); chk("t1_b1_wait", w, 0);
    beat(8'd7, 8'd8, w); chk("t1_b2_wait", w, 0);
    chk("t1_vld_now", {31'd0, out_valid}, 32'd1);
    get_result("t1", 16'h0062, 1'b0, 0);
    chk("t1_latency", lat, 4);

    // Single-step carry out of bit 15.
    do_start(16'hFFF0, 8'd1);
    beat(8'd255, 8'd255, w);
`ifdef MAC_SATURATE_EN
    get_result("t2", 16'hFFFF, 1'b1, 0);
`else
    get_result("t2", 16'hFDF1, 1'b1, 0);
`endif

    // Zero-length vector goes straight to DONE.
    saw_rdy = 1'b0; mon = 1'b1;
    do_start(16'h1234, 8'd0);
    get_result("t3", 16'h1234, 1'b0, 0);
    chk("t3_latency", lat, 1);
    mon = 1'b0;
    chk("t3_no_rdy", {31'd0, saw_rdy}, 32'd0);

    // Stalled input, held output, stray starts.
    do_start(16'h0000, 8'd2);
    beat(8'd10, 8'd10, w);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin start = 1'b1; init = 16'hFFFF; len = 8'd0; end
      @(negedge clk);
      start = 1'b0;
      chk("t4_gap_rdy", {31'd0, in_ready}, 32'd1);
    end
    beat(8'd2, 8'd3, w);
    get_result("t4", 16'h006A, 1'b0, 5);

    // Asynchronous reset in the middle of a vector.
    do_start(16'h0500, 8'd4);
    beat(8'd9, 8'd9, w);
    beat(8'd4, 8'd4, w);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_rdy", {31'd0, in_ready}, 32'd0);
    chk("t5_vld", {31'd0, out_valid}, 32'd0);
    chk("t5_acc", {16'd0, out_acc}, 32'd0);
    chk("t5_ovf", {31'd0, out_ovf}, 32'd0);
    chk("t5_macx", {16'd0, mac_x}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(16'h0000, 8'd1);
    beat(8'd1, 8'd1, w);
    get_result("t5_after", 16'h0001, 1'b0, 0);

    // Random vectors against an exact-sum model.
    for (int v = 0; v < 1000; v++) begin
      ri = 16'($urandom);
      rl = 8'($urandom_range(1, 16));
      tsum = {16'd0, ri};
      do_start(ri, rl);
      for (int j = 0; j < int'(rl); j++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        ra = 8'($urandom);
        rb = 8'($urandom);
        tsum = tsum + {24'd0, ra} * {24'd0, rb};
        beat(ra, rb, w);
      end
`ifdef MAC_SATURATE_EN
      ea = (tsum > 32'hFFFF) ? 16'hFFFF : tsum[15:0];
`else
      ea = tsum[15:0];
`endif
      get_result("rnd", ea, tsum > 32'hFFFF, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
